// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg : shared FSM encoding and datapath widths. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;
endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr : counts ACCESS cycles, flags the last allowed one. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic expire_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == LAST);
endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access : MEM stage, one LW/SW at a time over a req/ack data port.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  dst_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic                rw_q, rw_d;
    logic                we_q, we_d;
    logic                mis_q, mis_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_rw_q, wb_rw_d;
    logic [REG_W-1:0]    wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                err_q, err_d;
    logic                expire;
    logic                mem_op;
    logic                illegal;

    assign mem_op  = mem_read ^ mem_write;
    assign illegal = mem_read & mem_write;

`ifdef MEM_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (state_q == ACCESS),
        .expire_o (expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expire         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        rw_d       = rw_q;
        we_d       = we_q;
        mis_d      = mis_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        err_d      = 1'b0;
        if (state_q == IDLE) begin
            if (mem_op) begin
                state_d = ACCESS;
                addr_d  = {alu_result[DATA_W-1:1], 1'b0};
                wdata_d = write_data;
                dst_d   = dst_reg;
                rw_d    = reg_write;
                we_d    = mem_write;
                mis_d   = alu_result[0];
            end else begin
                wb_valid_d = 1'b1;
                wb_dst_d   = dst_reg;
                wb_data_d  = alu_result;
                wb_rw_d    = reg_write & ~illegal;
                err_d      = illegal;
            end
        end else if (dmem_ack) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_dst_d   = dst_q;
            wb_rw_d    = rw_q & ~we_q;
            wb_data_d  = we_q ? addr_q : dmem_rdata;
            err_d      = mis_q;
        end else if (expire) begin
            // Aborted access reports the address it gave up on.
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_dst_d   = dst_q;
            wb_data_d  = addr_q;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            rw_q       <= 1'b0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dst_q      <= dst_d;
            rw_q       <= rw_d;
            we_q       <= we_d;
            mis_q      <= mis_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    // Stall is gated by rst_n so it falls with reset, not at the next edge.
    assign stall = rst_n & ((state_q == IDLE) ? mem_op : (~dmem_ack & ~expire));

    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = (state_q == ACCESS) & we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_dst       = wb_dst_q;
    assign wb_data      = wb_data_q;
    assign err          = err_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access : directed scoreboard bench for mem_access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, reg_write;
    logic [15:0] alu_result, write_data;
    logic [3:0]  dst_reg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, wb_valid, wb_reg_write, err;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rw;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        err;
    } wb_t;

    wb_t sb[$];

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .reg_write    (reg_write),
        .dst_reg      (dst_reg),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic wb_t mk(input logic rw, input logic [3:0] dst,
                               input logic [15:0] data, input logic e);
        wb_t w;
        w.rw   = rw;
        w.dst  = dst;
        w.data = data;
        w.err  = e;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, act, exp);
        end
    endtask

    // Check combinational/registered outputs mid-cycle, then optionally
    // enqueue the writeback that the current inputs will produce.
    task automatic cycle(input logic exp_stall, input logic exp_req,
                         input logic push, input wb_t e, input string tag);
        wb_t got;
        logic exp_v;
        @(negedge clk);
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, exp_stall});
        chk({tag, ".req"}, {15'd0, dmem_req}, {15'd0, exp_req});
        exp_v = (sb.size() > 0);
        chk({tag, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, exp_v});
        if (exp_v) begin
            got = sb.pop_front();
            chk({tag, ".wb_rw"}, {15'd0, wb_reg_write}, {15'd0, got.rw});
            chk({tag, ".wb_dst"}, {12'd0, wb_dst}, {12'd0, got.dst});
            chk({tag, ".wb_data"}, wb_data, got.data);
            chk({tag, ".err"}, {15'd0, err}, {15'd0, got.err});
        end else begin
            chk({tag, ".err"}, {15'd0, err}, 16'd0);
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [15:0] a, input logic rw, input logic [3:0] d,
                       input string tag);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_result = a;
        reg_write  = rw;
        dst_reg    = d;
        cycle(1'b0, 1'b0, 1'b1, mk(rw, d, a, 1'b0), tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_result = '0;
        write_data = '0;
        dst_reg    = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #1;
        chk("rst.req", {15'd0, dmem_req}, 16'd0);
        chk("rst.we", {15'd0, dmem_we}, 16'd0);
        chk("rst.stall", {15'd0, stall}, 16'd0);
        chk("rst.wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst.wb_rw", {15'd0, wb_reg_write}, 16'd0);
        chk("rst.err", {15'd0, err}, 16'd0);
        chk("rst.addr", dmem_addr, 16'd0);
        chk("rst.wdata", dmem_wdata, 16'd0);
        chk("rst.wb_dst", {12'd0, wb_dst}, 16'd0);
        chk("rst.wb_data", wb_data, 16'd0);
        cycle(1'b0, 1'b0, 1'b0, '0, "rst0");
        cycle(1'b0, 1'b0, 1'b0, '0, "rst1");
        rst_n = 1'b1;

        nop(16'h1234, 1'b1, 4'd3, "nop1");
        nop(16'h0000, 1'b0, 4'd0, "nop2");
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hDEAD;
        nop(16'h0055, 1'b1, 4'd9, "ack_idle");
        dmem_ack   = 1'b0;

        // LW, ack on the second ACCESS cycle
        mem_read = 1'b1; alu_result = 16'h0040; reg_write = 1'b1; dst_reg = 4'd5;
        cycle(1'b1, 1'b0, 1'b0, '0, "lw_pres");
        chk("lw.addr", dmem_addr, 16'h0040);
        chk("lw.we", {15'd0, dmem_we}, 16'd0);
        cycle(1'b1, 1'b1, 1'b0, '0, "lw_acc1");
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        cycle(1'b0, 1'b1, 1'b1, mk(1'b1, 4'd5, 16'hBEEF, 1'b0), "lw_acc2");
        dmem_ack = 1'b0;

        // SW, immediate ack
        mem_read = 1'b0; mem_write = 1'b1; alu_result = 16'h0010;
        write_data = 16'hA5A5; reg_write = 1'b1; dst_reg = 4'd7;
        cycle(1'b1, 1'b0, 1'b0, '0, "sw_pres");
        dmem_ack = 1'b1;
        chk("sw.we", {15'd0, dmem_we}, 16'd1);
        chk("sw.wdata", dmem_wdata, 16'hA5A5);
        chk("sw.addr", dmem_addr, 16'h0010);
        cycle(1'b0, 1'b1, 1'b1, mk(1'b0, 4'd7, 16'h0010, 1'b0), "sw_acc");
        dmem_ack = 1'b0;

        // Both read and write: illegal, no access
        mem_read = 1'b1; mem_write = 1'b1; alu_result = 16'h2222;
        reg_write = 1'b1; dst_reg = 4'd2;
        cycle(1'b0, 1'b0, 1'b1, mk(1'b0, 4'd2, 16'h2222, 1'b1), "both");

        // Misaligned LW
        mem_write = 1'b0; alu_result = 16'h0083; dst_reg = 4'd4;
        cycle(1'b1, 1'b0, 1'b0, '0, "mis_pres");
        chk("mis.addr", dmem_addr, 16'h0082);
        dmem_ack = 1'b1; dmem_rdata = 16'h1357;
        cycle(1'b0, 1'b1, 1'b1, mk(1'b1, 4'd4, 16'h1357, 1'b1), "mis_acc");
        dmem_ack = 1'b0;

        // Slow or absent ack
        alu_result = 16'h0100; dst_reg = 4'd6;
        cycle(1'b1, 1'b0, 1'b0, '0, "slow_pres");
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0, "to_wait");
        cycle(1'b0, 1'b1, 1'b1, mk(1'b0, 4'd6, 16'h0100, 1'b1), "to_expire");
`else
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0, "slow_wait");
        dmem_ack = 1'b1; dmem_rdata = 16'h4242;
        cycle(1'b0, 1'b1, 1'b1, mk(1'b1, 4'd6, 16'h4242, 1'b0), "slow_ack");
        dmem_ack = 1'b0;
`endif

        // Reset on the third ACCESS cycle
        mem_read = 1'b1; alu_result = 16'h0200; dst_reg = 4'd8;
        cycle(1'b1, 1'b0, 1'b0, '0, "rs_pres");
        cycle(1'b1, 1'b1, 1'b0, '0, "rs_acc1");
        cycle(1'b1, 1'b1, 1'b0, '0, "rs_acc2");
        rst_n = 1'b0;
        #1;
        chk("rs.req_async", {15'd0, dmem_req}, 16'd0);
        chk("rs.stall_async", {15'd0, stall}, 16'd0);
        chk("rs.addr", dmem_addr, 16'd0);
        mem_read = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, '0, "rs_hold0");
        cycle(1'b0, 1'b0, 1'b0, '0, "rs_hold1");
        rst_n = 1'b1;
        nop(16'h0777, 1'b1, 4'd1, "post1");
        nop(16'h0000, 1'b0, 4'd0, "post2");
        cycle(1'b0, 1'b0, 1'b0, '0, "drain");
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
